calculation_accum: RTL and testbench

CALCULATION_ACCUM -- requirements
Module: calculation_accum

---
 rtl/calculation_accum.sv | 141 ++++++++++++++
 tb/tb_calculation_accum.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calculation_accum.sv
// calculation_accum: accumulates unsigned (x, y) samples into per-set sums and
// a sample count, then holds the result until the consumer takes it.
//
// Parameters:
//   WIDTH  coordinate width
//   ACC_W  accumulator width (must be >= WIDTH+1)
//   CNT_W  sample-counter width
// Ports:
//   add_clk, add_rst_n       clock, asynchronous active-low reset
//   in_valid/in_ready        sample handshake; in_last marks the final sample
//   x, y                     unsigned sample coordinates
//   out_valid/out_ready      result handshake
//   sum_x, sum_y, count      accumulated result
//   ovf                      sticky overflow flag for the current set
// Build option:
//   CALC_ACCUM_SAT_EN        when defined, sums clamp at all-ones on overflow;
//                            otherwise they wrap modulo 2^ACC_W.
module calculation_accum #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ACC_W = 48,
    parameter int unsigned CNT_W = 16
) (
    input  logic             add_clk,
    input  logic             add_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum_x,
    output logic [ACC_W-1:0] sum_y,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic             transfer;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_x;
    logic [WIDTH-1:0] s1_y;
    logic [ACC_W:0]   add_x;
    logic [ACC_W:0]   add_y;
    logic [ACC_W-1:0] sum_x_nxt;
    logic [ACC_W-1:0] sum_y_nxt;
    logic             cnt_max;
    logic             release_out;

    assign transfer    = in_valid && in_ready;
    assign release_out = (state == OUT) && out_ready;

    // State register
    always_ff @(posedge add_clk or negedge add_rst_n) begin
        if (!add_rst_n) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACC: begin
                in_ready = 1'b1;
                if (transfer && in_last) begin
                    state_nxt = DRAIN;
                end
            end
            // One cycle for the last sample to pass through stage 2
            DRAIN: state_nxt = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ACC;
                end
            end
            default: state_nxt = ACC;
        endcase
    end

    // Stage 1: register the accepted sample
    always_ff @(posedge add_clk or negedge add_rst_n) begin
        if (!add_rst_n) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
        end else begin
            s1_valid <= transfer;
            if (transfer) begin
                s1_x <= x;
                s1_y <= y;
            end
        end
    end

    // Stage 2 arithmetic: one extra bit captures the carry out of the MSB
    assign add_x   = {1'b0, sum_x} + {{(ACC_W + 1 - WIDTH){1'b0}}, s1_x};
    assign add_y   = {1'b0, sum_y} + {{(ACC_W + 1 - WIDTH){1'b0}}, s1_y};
    assign cnt_max = &count;

`ifdef CALC_ACCUM_SAT_EN
    assign sum_x_nxt = add_x[ACC_W] ? '1 : add_x[ACC_W-1:0];
    assign sum_y_nxt = add_y[ACC_W] ? '1 : add_y[ACC_W-1:0];
`else
    assign sum_x_nxt = add_x[ACC_W-1:0];
    assign sum_y_nxt = add_y[ACC_W-1:0];
`endif

    // Stage 2: accumulate; results clear on the edge the consumer takes them
    always_ff @(posedge add_clk or negedge add_rst_n) begin
        if (!add_rst_n) begin
            sum_x <= '0;
            sum_y <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (release_out) begin
            sum_x <= '0;
            sum_y <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (s1_valid) begin
            sum_x <= sum_x_nxt;
            sum_y <= sum_y_nxt;
            count <= cnt_max ? count : count + CNT_W'(1);
            ovf   <= ovf | add_x[ACC_W] | add_y[ACC_W] | cnt_max;
        end
    end

endmodule

// File: tb/tb_calculation_accum.sv
module tb_calculation_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] x = '0;
    logic [31:0] y = '0;

    // Instance A: default widths
    logic        in_ready_a, out_valid_a, ovf_a;
    logic [47:0] sum_x_a, sum_y_a;
    logic [15:0] count_a;
    // Instance B: narrow accumulator and counter to reach overflow quickly
    logic        in_ready_b, out_valid_b, ovf_b;
    logic [32:0] sum_x_b, sum_y_b;
    logic [1:0]  count_b;

    int unsigned checks = 0;
    int unsigned errors = 0;

    calculation_accum dut_a (
        .add_clk(clk), .add_rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_last(in_last),
        .x(x), .y(y),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .sum_x(sum_x_a), .sum_y(sum_y_a), .count(count_a), .ovf(ovf_a)
    );

    calculation_accum #(.WIDTH(32), .ACC_W(33), .CNT_W(2)) dut_b (
        .add_clk(clk), .add_rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_last(in_last),
        .x(x), .y(y),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .sum_x(sum_x_b), .sum_y(sum_y_b), .count(count_b), .ovf(ovf_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: phase 0 = accepting, 1 = draining, 2 = result held.
    // Ideal (unbounded) totals are kept; width effects are applied when compared.
    int unsigned m_phase;
    logic [63:0] m_n, m_sx, m_sy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_n     <= '0;
            m_sx    <= '0;
            m_sy    <= '0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_n  <= m_n + 64'd1;
                    m_sx <= m_sx + 64'(x);
                    m_sy <= m_sy + 64'(y);
                    if (in_last) m_phase <= 1;
                end
                1: m_phase <= 2;
                default: if (out_ready) begin
                    m_phase <= 0;
                    m_n     <= '0;
                    m_sx    <= '0;
                    m_sy    <= '0;
                end
            endcase
        end
    end

    function automatic logic [63:0] exp_sum(input logic [63:0] t, input int unsigned w);
        logic [63:0] mx;
        mx = (64'd1 << w) - 64'd1;
`ifdef CALC_ACCUM_SAT_EN
        return (t > mx) ? mx : t;
`else
        return t & mx;
`endif
    endfunction

    function automatic logic [63:0] exp_cnt(input logic [63:0] n, input int unsigned cw);
        logic [63:0] mx;
        mx = (64'd1 << cw) - 64'd1;
        return (n > mx) ? mx : n;
    endfunction

    function automatic logic exp_ovf(input logic [63:0] n, input logic [63:0] sx,
                                     input logic [63:0] sy, input int unsigned w,
                                     input int unsigned cw);
        logic [63:0] mx, cmx;
        mx  = (64'd1 << w) - 64'd1;
        cmx = (64'd1 << cw) - 64'd1;
        return (sx > mx) || (sy > mx) || (n > cmx);
    endfunction

    // Compare process: every cycle on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid_a", 64'(out_valid_a), 64'd0);
            chk("rst_sum_x_a", 64'(sum_x_a), 64'd0);
            chk("rst_sum_y_a", 64'(sum_y_a), 64'd0);
            chk("rst_count_a", 64'(count_a), 64'd0);
            chk("rst_ovf_a", 64'(ovf_a), 64'd0);
            chk("rst_out_valid_b", 64'(out_valid_b), 64'd0);
        end else begin
            chk("in_ready_a", 64'(in_ready_a), 64'(m_phase == 0));
            chk("in_ready_b", 64'(in_ready_b), 64'(m_phase == 0));
            chk("out_valid_a", 64'(out_valid_a), 64'(m_phase == 2));
            chk("out_valid_b", 64'(out_valid_b), 64'(m_phase == 2));
            if (m_phase == 2) begin
                chk("sum_x_a", 64'(sum_x_a), exp_sum(m_sx, 48));
                chk("sum_y_a", 64'(sum_y_a), exp_sum(m_sy, 48));
                chk("count_a", 64'(count_a), exp_cnt(m_n, 16));
                chk("ovf_a", 64'(ovf_a), 64'(exp_ovf(m_n, m_sx, m_sy, 48, 16)));
                chk("sum_x_b", 64'(sum_x_b), exp_sum(m_sx, 33));
                chk("sum_y_b", 64'(sum_y_b), exp_sum(m_sy, 33));
                chk("count_b", 64'(count_b), exp_cnt(m_n, 2));
                chk("ovf_b", 64'(ovf_b), 64'(exp_ovf(m_n, m_sx, m_sy, 33, 2)));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] sx, input logic [31:0] sy, input logic last);
        in_valid = 1'b1;
        x        = sx;
        y        = sy;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_out();
        int unsigned k;
        k = 0;
        while (!out_valid_a && k < 8) begin
            step();
            k++;
        end
        if (!out_valid_a) begin
            checks++;
            errors++;
            $display("FAIL wait_out: out_valid still 0 after %0d cycles, expected 1", k);
        end
    endtask

    // Hold the result for 'hold' cycles (optionally with junk input traffic), then take it
    task automatic release_out(input int unsigned hold, input bit junk);
        for (int unsigned i = 0; i < hold; i++) begin
            if (junk) begin
                in_valid = 1'b1;
                in_last  = 1'($urandom_range(0, 1));
                x        = $urandom;
                y        = $urandom;
            end
            step();
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        do_reset();

        // Three back-to-back samples; result appears on the second cycle after the last edge
        send(32'd1, 32'd2, 1'b0);
        send(32'd3, 32'd4, 1'b0);
        send(32'd5, 32'd6, 1'b1);
        chk("lat_drain_low", 64'(out_valid_a), 64'd0);
        step();
        chk("lat_out_high", 64'(out_valid_a), 64'd1);
        chk("lit_sum_x_9", 64'(sum_x_a), 64'd9);
        chk("lit_sum_y_12", 64'(sum_y_a), 64'd12);
        chk("lit_count_3", 64'(count_a), 64'd3);
        chk("lit_ovf_0", 64'(ovf_a), 64'd0);
        release_out(0, 1'b0);

        // Single-sample set
        send(32'hFFFF_FFFF, 32'd0, 1'b1);
        wait_out();
        chk("lit_single_sx", 64'(sum_x_a), 64'hFFFF_FFFF);
        chk("lit_single_sy", 64'(sum_y_a), 64'd0);
        chk("lit_single_cnt", 64'(count_a), 64'd1);
        release_out(0, 1'b0);

        // Consumer stalls 5 cycles with input traffic present
        send(32'd10, 32'd20, 1'b0);
        send(32'd30, 32'd40, 1'b1);
        wait_out();
        release_out(5, 1'b1);
        send(32'd1, 32'd1, 1'b1);
        wait_out();
        chk("lit_fresh_sx", 64'(sum_x_a), 64'd1);
        chk("lit_fresh_cnt", 64'(count_a), 64'd1);
        release_out(0, 1'b0);

        // Sum overflow on the 33-bit instance
        send(32'hFFFF_FFFF, 32'd1, 1'b0);
        send(32'hFFFF_FFFF, 32'd1, 1'b0);
        send(32'hFFFF_FFFF, 32'd1, 1'b1);
        wait_out();
        chk("lit_ovf33", 64'(ovf_b), 64'd1);
`ifdef CALC_ACCUM_SAT_EN
        chk("lit_sx33", 64'(sum_x_b), 64'h1_FFFF_FFFF);
`else
        chk("lit_sx33", 64'(sum_x_b), 64'h0_FFFF_FFFD);
`endif
        chk("lit_sx48", 64'(sum_x_a), 64'h2_FFFF_FFFD);
        chk("lit_ovf48", 64'(ovf_a), 64'd0);
        release_out(0, 1'b0);

        // Count saturation on the 2-bit counter
        for (int unsigned i = 0; i < 5; i++) send(32'd1, 32'd1, 1'(i == 4));
        wait_out();
        chk("lit_cnt_sat", 64'(count_b), 64'd3);
        chk("lit_cnt_ovf", 64'(ovf_b), 64'd1);
        chk("lit_cnt_wide", 64'(count_a), 64'd5);
        release_out(0, 1'b0);

        // Reset mid-set discards the partial sums
        send(32'd100, 32'd200, 1'b0);
        send(32'd300, 32'd400, 1'b0);
        do_reset();
        send(32'd7, 32'd8, 1'b1);
        wait_out();
        chk("lit_rst_sx", 64'(sum_x_a), 64'd7);
        chk("lit_rst_sy", 64'(sum_y_a), 64'd8);
        chk("lit_rst_cnt", 64'(count_a), 64'd1);
        release_out(0, 1'b0);

        // Randomized sets with gaps, stalls and occasional resets
        for (int unsigned s = 0; s < 60; s++) begin
            int unsigned k;
            bit rst_mid, rst_in_out;
            k          = $urandom_range(1, 6);
            rst_mid    = ($urandom_range(0, 9) == 0) && (k > 1);
            rst_in_out = ($urandom_range(0, 14) == 0);
            for (int unsigned j = 0; j < k; j++) begin
                int unsigned gap;
                logic [31:0] vx, vy;
                gap = $urandom_range(0, 2);
                for (int unsigned g = 0; g < gap; g++) begin
                    x = $urandom;
                    y = $urandom;
                    in_last = 1'($urandom_range(0, 1));
                    step();
                end
                vx = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255));
                vy = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255));
                send(vx, vy, 1'(j == k - 1));
                if (rst_mid && j == k / 2 - 1) do_reset();
            end
            wait_out();
            if (rst_in_out) begin
                do_reset();
                step();
            end else begin
                release_out($urandom_range(0, 3), 1'($urandom_range(0, 1)));
            end
        end

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
